// File: rtl/four_dispatch.sv
// rtl/four_dispatch.sv - buffered 1-to-4 stream dispatcher with per-channel FIFOs
// Optional broadcast dispatch enabled by defining FOUR_DISPATCH_BCAST_EN.
module four_dispatch #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       in_dest_i,
   input  logic [WIDTH-1:0] in_data_i,
`ifdef FOUR_DISPATCH_BCAST_EN
   input  logic             in_bcast_i,
`endif
   output logic [3:0]       out_valid_o,
   input  logic [3:0]       out_ready_i,
   output logic [WIDTH-1:0] out_data0_o,
   output logic [WIDTH-1:0] out_data1_o,
   output logic [WIDTH-1:0] out_data2_o,
   output logic [WIDTH-1:0] out_data3_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem_q  [4][DEPTH];
   logic [WIDTH-1:0] mem_d  [4][DEPTH];
   logic [PW-1:0]    wptr_q [4];
   logic [PW-1:0]    wptr_d [4];
   logic [PW-1:0]    rptr_q [4];
   logic [PW-1:0]    rptr_d [4];
   logic [PW:0]      cnt_q  [4];
   logic [PW:0]      cnt_d  [4];

   logic [3:0] full_w;
   logic [3:0] push_w;
   logic [3:0] pop_w;
   logic       bcast_w;
   logic       accept_w;

`ifdef FOUR_DISPATCH_BCAST_EN
   assign bcast_w = in_bcast_i;
`else
   assign bcast_w = 1'b0;
`endif

   always_comb begin
      full_w      = '0;
      out_valid_o = '0;
      for (int c = 0; c < 4; c++) begin
         full_w[c]      = (cnt_q[c] == DEPTH_CNT);
         out_valid_o[c] = (cnt_q[c] != '0);
      end
   end

   // Ready looks only at registered occupancy, never at out_ready_i.
   assign in_ready_o = bcast_w ? ~|full_w : ~full_w[in_dest_i];
   assign accept_w   = in_valid_i & in_ready_o;

   always_comb begin
      push_w = '0;
      pop_w  = '0;
      for (int c = 0; c < 4; c++) begin
         push_w[c] = accept_w & (bcast_w | (in_dest_i == c[1:0]));
         pop_w[c]  = out_valid_o[c] & out_ready_i[c];
      end
   end

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      for (int c = 0; c < 4; c++) begin
         if (push_w[c]) begin
            mem_d[c][wptr_q[c]] = in_data_i;
            wptr_d[c]           = wptr_q[c] + PW'(1);
         end
         if (pop_w[c]) begin
            rptr_d[c] = rptr_q[c] + PW'(1);
         end
         case ({push_w[c], pop_w[c]})
            2'b10:   cnt_d[c] = cnt_q[c] + (PW+1)'(1);
            2'b01:   cnt_d[c] = cnt_q[c] - (PW+1)'(1);
            default: cnt_d[c] = cnt_q[c];
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int c = 0; c < 4; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
            cnt_q[c]  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               mem_q[c][e] <= '0;
            end
         end
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_data0_o = mem_q[0][rptr_q[0]];
   assign out_data1_o = mem_q[1][rptr_q[1]];
   assign out_data2_o = mem_q[2][rptr_q[2]];
   assign out_data3_o = mem_q[3][rptr_q[3]];

endmodule

// File: tb/tb_four_dispatch.sv
// tb/tb_four_dispatch.sv - directed self-checking bench for four_dispatch
// Broadcast cases compile in when FOUR_DISPATCH_BCAST_EN is defined.
module tb_four_dispatch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_dest;
   logic [31:0] in_data;
`ifdef FOUR_DISPATCH_BCAST_EN
   logic        in_bcast;
`endif
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data0, out_data1, out_data2, out_data3;

   int n_checks = 0;
   int n_errors = 0;

   four_dispatch #(.WIDTH(32), .DEPTH(2)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_dest_i   (in_dest),
      .in_data_i   (in_data),
`ifdef FOUR_DISPATCH_BCAST_EN
      .in_bcast_i  (in_bcast),
`endif
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data0_o (out_data0),
      .out_data1_o (out_data1),
      .out_data2_o (out_data2),
      .out_data3_o (out_data3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] data_of(input int ch);
      case (ch)
         0:       return out_data0;
         1:       return out_data1;
         2:       return out_data2;
         default: return out_data3;
      endcase
   endfunction

   initial begin
      int          dests [5];
      logic [3:0]  exp_v;
      dests = '{0, 1, 2, 3, 0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_dest   = 2'd0;
      in_data   = '0;
      out_ready = 4'b0000;
`ifdef FOUR_DISPATCH_BCAST_EN
      in_bcast  = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_out_valid", {28'd0, out_valid}, 32'h0);
      check("rst_in_ready", {31'd0, in_ready}, 32'h1);
      for (int c = 0; c < 4; c++) check($sformatf("rst_data%0d", c), data_of(c), 32'h0);
      @(negedge clk);

      // Unicast ordering on channel 1
      in_valid = 1'b1; in_dest = 2'd1; in_data = 32'hA1;
      tick();
      in_data = 32'hA2;
      tick();
      in_valid = 1'b0;
      #1;
      check("uni_valid", {28'd0, out_valid}, 32'h2);
      check("uni_head", out_data1, 32'hA1);
      in_dest = 2'd1; #1;
      check("uni_ready_d1_full", {31'd0, in_ready}, 32'h0);
      in_dest = 2'd3; #1;
      check("uni_ready_d3", {31'd0, in_ready}, 32'h1);
      out_ready = 4'b0010;
      tick();
      check("uni_second", out_data1, 32'hA2);
      check("uni_valid2", {28'd0, out_valid}, 32'h2);
      tick();
      check("uni_drained", {28'd0, out_valid}, 32'h0);
      out_ready = 4'b0000;

      // Full channel 0 with simultaneous pop
      in_valid = 1'b1; in_dest = 2'd0; in_data = 32'h01;
      tick();
      in_data = 32'h02;
      tick();
      in_data = 32'h55; out_ready = 4'b0001;
      #1;
      check("full_ready_low", {31'd0, in_ready}, 32'h0);
      check("full_head", out_data0, 32'h01);
      tick();
      out_ready = 4'b0000;
      #1;
      check("full_after_pop_head", out_data0, 32'h02);
      check("full_after_pop_ready", {31'd0, in_ready}, 32'h1);
      tick();
      in_valid = 1'b0; out_ready = 4'b0001;
      #1;
      check("full_rem_head", out_data0, 32'h02);
      tick();
      check("full_tail", out_data0, 32'h55);
      check("full_tail_valid", {28'd0, out_valid}, 32'h1);
      tick();
      check("full_empty", {28'd0, out_valid}, 32'h0);
      out_ready = 4'b0000;

      // Wrap-around stream to channel 3
      out_ready = 4'b1000; in_dest = 2'd3;
      for (int k = 0; k <= 10; k++) begin
         in_valid = (k < 10);
         in_data  = k;
         #1;
         if (k >= 1) begin
            check($sformatf("wrap_valid_%0d", k), {28'd0, out_valid}, 32'h8);
            check($sformatf("wrap_data_%0d", k), out_data3, k - 1);
         end
         if (k < 10) check($sformatf("wrap_ready_%0d", k), {31'd0, in_ready}, 32'h1);
         tick();
      end
      check("wrap_empty", {28'd0, out_valid}, 32'h0);

      // Interleaved destinations, all consumers ready
      out_ready = 4'b1111;
      for (int k = 0; k <= 5; k++) begin
         in_valid = (k < 5);
         if (k < 5) begin
            in_dest = dests[k][1:0];
            in_data = 10 + k;
         end
         #1;
         if (k >= 1) begin
            exp_v = 4'b0001 << dests[k-1];
            check($sformatf("ilv_valid_%0d", k), {28'd0, out_valid}, {28'd0, exp_v});
            check($sformatf("ilv_data_%0d", k), data_of(dests[k-1]), 10 + k - 1);
         end
         tick();
      end
      check("ilv_empty", {28'd0, out_valid}, 32'h0);
      out_ready = 4'b0000;

`ifdef FOUR_DISPATCH_BCAST_EN
      // Broadcast blocked by full channel 2
      in_valid = 1'b1; in_dest = 2'd2; in_data = 32'h21;
      tick();
      in_data = 32'h22;
      tick();
      in_bcast = 1'b1; in_dest = 2'd0; in_data = 32'h77;
      #1;
      check("bc_ready_low", {31'd0, in_ready}, 32'h0);
      out_ready = 4'b0100;
      tick();
      out_ready = 4'b0000;
      #1;
      check("bc_ready_high", {31'd0, in_ready}, 32'h1);
      tick();
      in_valid = 1'b0; in_bcast = 1'b0;
      #1;
      check("bc_valid", {28'd0, out_valid}, 32'hF);
      check("bc_d0", out_data0, 32'h77);
      check("bc_d1", out_data1, 32'h77);
      check("bc_d3", out_data3, 32'h77);
      check("bc_d2_head", out_data2, 32'h22);
      out_ready = 4'b1111;
      tick();
      out_ready = 4'b0000;
      check("bc_d2_tail", out_data2, 32'h77);
      check("bc_valid2", {28'd0, out_valid}, 32'h4);
      out_ready = 4'b0100;
      tick();
      out_ready = 4'b0000;
      check("bc_empty", {28'd0, out_valid}, 32'h0);
`endif

      // Asynchronous reset with channel 2 holding two words
      in_valid = 1'b1; in_dest = 2'd2; in_data = 32'hC1;
      tick();
      in_data = 32'hC2;
      tick();
      in_valid = 1'b0;
      #1;
      check("ar_before", {28'd0, out_valid}, 32'h4);
      check("ar_before_data", out_data2, 32'hC1);
      #1 rst_n = 1'b0;
      #1;
      check("ar_valid_drop", {28'd0, out_valid}, 32'h0);
      check("ar_data_clear", out_data2, 32'h0);
      check("ar_ready", {31'd0, in_ready}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("ar_still_empty", {28'd0, out_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
